// File: rtl/alu_issue_ctrl_if.sv
// Issue/RF/ALU/writeback bundle for alu_issue_ctrl; master = sequencer, slave = environment.
// retired_count exists only when STATS_EN is defined.
interface alu_issue_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic [4:0]      rf_rs1_addr;
  logic [4:0]      rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_data;
  logic [XLEN-1:0] rf_rs2_data;
  logic [XLEN-1:0] alu_op1;
  logic [XLEN-1:0] alu_op2;
  logic [2:0]      alu_funct3;
  logic            alu_funct7;
  logic [XLEN-1:0] adder_rsv;
  logic [XLEN-1:0] shifter_rsv;
  logic [XLEN-1:0] comparator_rsv;
  logic            rf_wr_en;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic            done;
  logic            illegal;
`ifdef STATS_EN
  logic [CNT_W-1:0] retired_count;
`endif

  modport master (
    input  instr_valid, instr, rf_rs1_data, rf_rs2_data,
           adder_rsv, shifter_rsv, comparator_rsv,
    output instr_ready, rf_rs1_addr, rf_rs2_addr, alu_op1, alu_op2,
           alu_funct3, alu_funct7, rf_wr_en, rf_wr_addr, rf_wr_data,
           done, illegal
`ifdef STATS_EN
   ,output retired_count
`endif
  );

  modport slave (
    output instr_valid, instr, rf_rs1_data, rf_rs2_data,
           adder_rsv, shifter_rsv, comparator_rsv,
    input  instr_ready, rf_rs1_addr, rf_rs2_addr, alu_op1, alu_op2,
           alu_funct3, alu_funct7, rf_wr_en, rf_wr_addr, rf_wr_data,
           done, illegal
`ifdef STATS_EN
   ,input  retired_count
`endif
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-cycle RV32I ALU issue/writeback sequencer: IDLE -> READ -> EXEC -> WB.
// Define STATS_EN to add the retired-instruction counter (retired_count).
module alu_issue_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  alu_issue_ctrl_if.master bus
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_e;

  state_e          state_q,   state_d;
  logic [31:0]     instr_q,   instr_d;
  logic [XLEN-1:0] op1_q,     op1_d;
  logic [XLEN-1:0] op2_q,     op2_d;
  logic [2:0]      funct3_q,  funct3_d;
  logic            funct7_q,  funct7_d;
  logic [XLEN-1:0] res_q,     res_d;
  logic            wr_en_q,   wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic            done_q,    done_d;
  logic            illegal_q, illegal_d;
`ifdef STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic            is_op;
  logic            is_opimm;
  logic            legal;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_sext;

  assign is_op    = (instr_q[6:0] == OPC_OP);
  assign is_opimm = (instr_q[6:0] == OPC_OPIMM);
  assign legal    = is_op | is_opimm;
  assign f3       = instr_q[14:12];
  assign rd       = instr_q[11:7];
  assign imm_sext = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    res_d     = res_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef STATS_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        op1_d    = bus.rf_rs1_data;
        op2_d    = is_opimm ? imm_sext : bus.rf_rs2_data;
        funct3_d = f3;
        // instr[30] only selects sub (OP) or arithmetic right shift; addi must never subtract.
        if (is_op)
          funct7_d = instr_q[30] & ((f3 == 3'b000) || (f3 == 3'b101));
        else if (is_opimm)
          funct7_d = instr_q[30] & (f3 == 3'b101);
        else
          funct7_d = 1'b0;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        case (funct3_q)
          3'b001, 3'b101: res_d = bus.shifter_rsv;
          3'b010, 3'b011: res_d = bus.comparator_rsv;
          default:        res_d = bus.adder_rsv;
        endcase
        state_d = S_WB;
      end
      S_WB: begin
        wr_en_d   = legal && (rd != 5'd0);
        wr_addr_d = rd;
        wr_data_d = res_q;
        done_d    = 1'b1;
        illegal_d = ~legal;
`ifdef STATS_EN
        if (legal)
          cnt_d = cnt_q + CNT_W'(1);
`endif
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      funct3_q  <= '0;
      funct7_q  <= 1'b0;
      res_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef STATS_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      res_q     <= res_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef STATS_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Read addresses come straight from the latched instruction, so they are registered at accept.
  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.rf_rs1_addr = instr_q[19:15];
  assign bus.rf_rs2_addr = instr_q[24:20];
  assign bus.alu_op1     = op1_q;
  assign bus.alu_op2     = op2_q;
  assign bus.alu_funct3  = funct3_q;
  assign bus.alu_funct7  = funct7_q;
  assign bus.rf_wr_en    = wr_en_q;
  assign bus.rf_wr_addr  = wr_addr_q;
  assign bus.rf_wr_data  = wr_data_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
`ifdef STATS_EN
  assign bus.retired_count = cnt_q;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, random instructions
// against an instruction-level reference, held-valid throughput and mid-operation reset.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();
  alu_issue_ctrl #(.XLEN(32), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] regs [32];
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr = 0;
  int n_done = 0;
`ifdef STATS_EN
  logic [31:0] exp_cnt = '0;
`endif

  typedef struct {
    logic [31:0] ins;
    logic [31:0] x1v;
    logic [31:0] x2v;
    logic        wr;
    logic [31:0] data;
    logic        ill;
    logic        cf7;
    logic        f7;
  } vec_t;
  vec_t tbl[$];

  typedef struct {
    int          lat;
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ill;
    logic        f7;
  } obs_t;

  // Register file (synchronous-read behaviour comes from the DUT's registered addresses).
  always_comb begin
    bus.rf_rs1_data = regs[bus.rf_rs1_addr];
    bus.rf_rs2_data = regs[bus.rf_rs2_addr];
  end

  // Combinational ALU: every unit always produces a value so a wrong result select shows up.
  always_comb begin
    case (bus.alu_funct3)
      3'b000:  bus.adder_rsv = bus.alu_funct7 ? bus.alu_op1 - bus.alu_op2 : bus.alu_op1 + bus.alu_op2;
      3'b100:  bus.adder_rsv = bus.alu_op1 ^ bus.alu_op2;
      3'b110:  bus.adder_rsv = bus.alu_op1 | bus.alu_op2;
      3'b111:  bus.adder_rsv = bus.alu_op1 & bus.alu_op2;
      default: bus.adder_rsv = bus.alu_op1 + bus.alu_op2;
    endcase
    if (!bus.alu_funct3[2])
      bus.shifter_rsv = bus.alu_op1 << bus.alu_op2[4:0];
    else if (bus.alu_funct7)
      bus.shifter_rsv = 32'($signed(bus.alu_op1) >>> bus.alu_op2[4:0]);
    else
      bus.shifter_rsv = bus.alu_op1 >> bus.alu_op2[4:0];
    if (bus.alu_funct3[0])
      bus.comparator_rsv = {31'b0, (bus.alu_op1 < bus.alu_op2)};
    else
      bus.comparator_rsv = {31'b0, ($signed(bus.alu_op1) < $signed(bus.alu_op2))};
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done)     n_done++;
      if (bus.rf_wr_en) n_wr++;
    end
  end

  function automatic logic [31:0] ref_res(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] rb);
    logic        imm_form;
    logic [31:0] b;
    logic [4:0]  sh;
    imm_form = (ins[6:0] == 7'h13);
    b  = imm_form ? {{20{ins[31]}}, ins[31:20]} : rb;
    sh = b[4:0];
    case (ins[14:12])
      3'd0:    return (!imm_form && ins[30]) ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] ins, input logic [31:0] x1v, input logic [31:0] x2v,
                         input logic wr, input logic [31:0] data, input logic ill,
                         input logic cf7, input logic f7);
    vec_t v;
    v.ins = ins; v.x1v = x1v; v.x2v = x2v; v.wr = wr; v.data = data;
    v.ill = ill; v.cf7 = cf7; v.f7 = f7;
    tbl.push_back(v);
  endtask

  task automatic issue(input string nm, input logic [31:0] ins, output obs_t o);
    int k;
    o.lat = 0; o.wr = 1'b0; o.wa = '0; o.wd = '0; o.ill = 1'b0; o.f7 = 1'b0;
    @(negedge clk);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    k = 0;
    while (!bus.instr_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
      bus.instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    do begin
      @(negedge clk);
      o.lat++;
      if (o.lat == 2) o.f7 = bus.alu_funct7;
    end while (!bus.done && o.lat < 12);
    o.wr = bus.rf_wr_en; o.wa = bus.rf_wr_addr; o.wd = bus.rf_wr_data; o.ill = bus.illegal;
    @(negedge clk);
    chk({nm, "_pulse"}, {30'b0, bus.done, bus.rf_wr_en}, 32'd0);
  endtask

  task automatic run_check(input string nm, input logic [31:0] ins, input logic exp_wr,
                           input logic [31:0] exp_data, input logic exp_ill,
                           input logic cf7, input logic exp_f7);
    obs_t o;
    issue(nm, ins, o);
    chk({nm, "_latency"}, o.lat, 32'd4);
    chk({nm, "_wr_en"}, {31'b0, o.wr}, {31'b0, exp_wr});
    if (exp_wr) begin
      chk({nm, "_wr_addr"}, {27'b0, o.wa}, {27'b0, ins[11:7]});
      chk({nm, "_wr_data"}, o.wd, exp_data);
      regs[ins[11:7]] = exp_data;
    end
    chk({nm, "_illegal"}, {31'b0, o.ill}, {31'b0, exp_ill});
    if (cf7) chk({nm, "_funct7"}, {31'b0, o.f7}, {31'b0, exp_f7});
`ifdef STATS_EN
    if (!exp_ill) exp_cnt = exp_cnt + 32'd1;
    chk({nm, "_retired"}, bus.retired_count, exp_cnt);
`endif
  endtask

  initial begin
    logic [31:0] ins, a, b, data, sum;
    logic [6:0]  opc;
    logic        legal, wr, f7;
    int          sel, w0, d0;

    for (int i = 0; i < 32; i++) regs[i] = '0;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.instr_ready}, 32'd1);
    chk("rst_flags", {29'b0, bus.done, bus.illegal, bus.rf_wr_en}, 32'd0);
    chk("rst_op1", bus.alu_op1, 32'd0);
    chk("rst_op2", bus.alu_op2, 32'd0);
    chk("rst_funct", {28'b0, bus.alu_funct7, bus.alu_funct3}, 32'd0);
    chk("rst_wr_bus", {bus.rf_wr_addr, bus.rf_rs1_addr, bus.rf_rs2_addr, 17'b0} | bus.rf_wr_data, 32'd0);
`ifdef STATS_EN
    chk("rst_retired", bus.retired_count, 32'd0);
`endif

    add_vec(32'h002081B3, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b1, 1'b0);               // add
    add_vec(32'h402081B3, 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1);         // sub
    add_vec(32'hFFF08193, 32'd5, 32'd7, 1'b1, 32'd4, 1'b0, 1'b1, 1'b0);                // addi -1
    add_vec(32'h40008193, 32'd5, 32'd7, 1'b1, 32'h405, 1'b0, 1'b1, 1'b0);              // addi 0x400
    add_vec(32'h4020D213, 32'hFFFFFFF0, 32'd0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1);  // srai
    add_vec(32'h0020D213, 32'hFFFFFFF0, 32'd0, 1'b1, 32'h3FFFFFFC, 1'b0, 1'b1, 1'b0);  // srli
    add_vec(32'h00208033, 32'd5, 32'd7, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);                // add x0
    add_vec(32'h0000006F, 32'd5, 32'd7, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);                // jal x0
    add_vec(32'h000001EF, 32'd5, 32'd7, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);                // jal x3
    add_vec(32'h0020F2B3, 32'hFFFFFFF0, 32'h3C, 1'b1, 32'h30, 1'b0, 1'b1, 1'b0);       // and
    add_vec(32'h0020A2B3, 32'hFFFFFFF0, 32'd7, 1'b1, 32'd1, 1'b0, 1'b1, 1'b0);         // slt
    add_vec(32'h0020B2B3, 32'hFFFFFFF0, 32'd7, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);         // sltu
    add_vec(32'h4020D2B3, 32'h80000000, 32'h24, 1'b1, 32'hF8000000, 1'b0, 1'b1, 1'b1); // sra, amt mod 32
    add_vec(32'h402092B3, 32'd1, 32'd31, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0);        // sll, bit30 ignored

    foreach (tbl[i]) begin
      regs[1] = tbl[i].x1v;
      regs[2] = tbl[i].x2v;
      run_check($sformatf("vec%0d", i), tbl[i].ins, tbl[i].wr, tbl[i].data, tbl[i].ill,
                tbl[i].cf7, tbl[i].f7);
    end

    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        do opc = 7'($urandom); while (opc == 7'h33 || opc == 7'h13);
      end else begin
        opc = (sel < 5) ? 7'h33 : 7'h13;
      end
      ins = $urandom;
      ins[6:0] = opc;
      if ($urandom_range(0, 3) == 0) ins[31:25] = {ins[31:30], 5'b0};
      legal = (opc == 7'h33) || (opc == 7'h13);
      a = regs[ins[19:15]];
      b = regs[ins[24:20]];
      data = ref_res(ins, a, b);
      wr = legal && (ins[11:7] != 5'd0);
      if (opc == 7'h33) f7 = ins[30] && (ins[14:12] == 3'd0 || ins[14:12] == 3'd5);
      else              f7 = ins[30] && (ins[14:12] == 3'd5);
      run_check($sformatf("rand%0d", i), ins, wr, data, !legal, legal, f7);
    end

    // instr_valid held high across three back-to-back instructions.
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    sum = regs[1] + regs[2];
    @(negedge clk);
    w0 = n_wr;
    d0 = n_done;
    bus.instr = 32'h00208333;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("held_ready%0d", i), {31'b0, bus.instr_ready}, {31'b0, (i % 4) == 0});
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_done_count", n_done - d0, 32'd3);
    chk("held_wr_count", n_wr - w0, 32'd3);
    regs[6] = sum;
`ifdef STATS_EN
    exp_cnt = exp_cnt + 32'd3;
    chk("held_retired", bus.retired_count, exp_cnt);
`endif

    // Reset while the instruction is in EXEC discards it.
    @(negedge clk);
    bus.instr = 32'h002083B3;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", {31'b0, bus.instr_ready}, 32'd1);
    chk("mid_rst_flags", {29'b0, bus.done, bus.illegal, bus.rf_wr_en}, 32'd0);
    chk("mid_rst_ops", bus.alu_op1 | bus.alu_op2, 32'd0);
    chk("mid_rst_funct", {28'b0, bus.alu_funct7, bus.alu_funct3}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    w0 = n_wr;
    d0 = n_done;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_write", n_wr - w0, 32'd0);
    chk("mid_rst_no_done", n_done - d0, 32'd0);
`ifdef STATS_EN
    exp_cnt = '0;
    chk("mid_rst_retired", bus.retired_count, exp_cnt);
`endif
    run_check("post_rst_add", 32'h002081B3, 1'b1, 32'd12, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end
endmodule
